mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the CPU's single-port synchronous memory between two requesters: the CPU control path (fetch, LDW, STW) and a secondary device port (program loader or DMA). It runs a three-state issue FSM with round-robin priority. It registers each granted request, drives exactly one MemRead or MemWrite pulse, and returns a one-cycle ack with registered read data. It sits between the CPU datapath memory-address/data muxes and the memory block.

Parameters:
ADDR_W, 8, width of memory word address.
DATA_W, 16, width of memory data word.

Ports:
CLK  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_req  in  1  CPU request; held high until cpu_ack.
cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
cpu_addr  in  ADDR_W  CPU word address.
cpu_wdata  in  DATA_W  CPU write data.
cpu_ack  out  1  one-cycle completion pulse to CPU.
cpu_rdata  out  DATA_W  registered read data for CPU; held until the next CPU read completes.
dev_req, dev_we, dev_addr, dev_wdata  in  1/1/ADDR_W/DATA_W  device request group; same rules as the CPU group.
dev_ack  out  1  one-cycle completion pulse to device.
dev_rdata  out  DATA_W  registered read data for device.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
MemRead  out  1  memory read strobe; memory returns data on the following cycle.
MemWrite  out  1  memory write strobe.
mem_rdata  in  DATA_W  memory read data, valid one cycle after MemRead.
busy  out  1  high in every state except IDLE.
owner  out  1  current or last grant: 0 = CPU, 1 = device.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE.
  - All strobes and acks = 0.
  - mem_addr, mem_wdata, cpu_rdata, dev_rdata = 0.
  - busy = 0, owner = 1. The device counts as last-granted, so the CPU wins the first tie.
  - Reset asserted mid-transaction aborts it: no ack, no strobe, and no rdata update on or after reset.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No requests: stay in IDLE.
  - Exactly one req high: grant that requester.
  - Both high: grant the requester that is not `owner` (round-robin).
  - On grant: latch addr, we and wdata into mem_addr, mem_wdata and an internal we_q; set owner = granted id; go to ISSUE.
- ISSUE (exactly one cycle):
  - MemRead = ~we_q, MemWrite = we_q.
  - If we_q = 1: assert the owner's ack in this cycle, then go to IDLE.
  - If we_q = 0: go to RESP.
- RESP (exactly one cycle):
  - Capture mem_rdata into the owner's rdata register at the end of the cycle.
  - Assert the owner's ack in this cycle; rdata is visible from the next cycle.
  - Go to IDLE.
- Latency from req sampled high in IDLE:
  - Write: ack on cycle +1.
  - Read: ack on cycle +2; rdata valid on cycle +3 onward.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Requester contract: deassert req on the clock edge where ack is seen. If req is still high when the FSM returns to IDLE, it is a new transaction.
- Arbiter side effects:
  - Changes to addr, we or wdata after grant have no effect; the latched values are used.
  - At most one ack per cycle.
  - MemRead and MemWrite are never high together.
  - The non-owner's rdata never changes.
- mem_addr and mem_wdata hold their last latched values in IDLE and RESP.
- A requester that raises req while the other is being served waits at least until the next IDLE. With round-robin it is granted no later than after one transaction of the other requester.

Test Plan:
- Reset then single CPU read: mem[0x10] = 0xBEEF, cpu_req = 1, cpu_we = 0, cpu_addr = 0x10 → MemRead high exactly 1 cycle with mem_addr = 0x10; cpu_ack 2 cycles after req sampled; cpu_rdata = 0xBEEF next cycle; dev_rdata stays 0.
- Device write: dev_we = 1, dev_addr = 0x22, dev_wdata = 0x1234 → MemWrite 1 cycle, dev_ack in the same cycle, owner = 1; a following CPU read of 0x22 returns 0x1234.
- Simultaneous requests after reset: both read (cpu addr 0x01, dev addr 0x02) → CPU served first, then device; grant order CPU, DEV, and continuing contention alternates CPU, DEV, CPU, DEV over 4 transactions.
- Address/data change after grant: flip cpu_addr from 0x05 to 0x06 during ISSUE → memory accessed at 0x05 only.
- Reset mid-read: assert reset during ISSUE of a CPU read → MemRead drops immediately, no cpu_ack, cpu_rdata = 0, busy = 0, state = IDLE; a fresh read afterwards completes normally.
- Back-to-back CPU writes with req held high across ack → two MemWrite pulses 2 cycles apart with the updated latched data; never MemRead and MemWrite high together.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one synchronous memory port between CPU and device
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dev_req,
  input  logic              dev_we,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [DATA_W-1:0] dev_wdata,
  output logic              dev_ack,
  output logic [DATA_W-1:0] dev_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  logic                we_q;
  logic                any_req;
  logic                grant_dev;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // On a tie the requester that did not hold the last grant wins.
  assign any_req   = cpu_req | dev_req;
  assign grant_dev = dev_req & (~cpu_req | ~owner);
  assign sel_we    = grant_dev ? dev_we    : cpu_we;
  assign sel_addr  = grant_dev ? dev_addr  : cpu_addr;
  assign sel_wdata = grant_dev ? dev_wdata : cpu_wdata;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      owner     <= 1'b1;
      busy      <= 1'b0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      cpu_ack   <= 1'b0;
      dev_ack   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dev_rdata <= '0;
    end else begin
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      cpu_ack  <= 1'b0;
      dev_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= grant_dev;
            we_q      <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            MemRead   <= ~sel_we;
            MemWrite  <= sel_we;
            // A write completes in the strobe cycle itself.
            cpu_ack   <= sel_we & ~grant_dev;
            dev_ack   <= sel_we & grant_dev;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cpu_ack <= ~owner;
            dev_ack <= owner;
            state   <= RESP;
          end
        end
        RESP: begin
          if (owner) begin
            dev_rdata <= mem_rdata;
          end else begin
            cpu_rdata <= mem_rdata;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dev_req, dev_we;
  logic [AW-1:0] cpu_addr, dev_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dev_wdata, mem_wdata, mem_rdata;
  logic          cpu_ack, dev_ack, MemRead, MemWrite, busy, owner;
  logic [DW-1:0] cpu_rdata, dev_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] m_rdata [2];
  bit            m_owner;

  logic          preload;
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_ack(dev_ack), .dev_rdata(dev_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_val(input int i);
    logic [DW-1:0] v;
    v = DW'(i) * 16'h9E37;
    return v ^ 16'h5A5A;
  endfunction

  // Single-port synchronous memory: read data appears the cycle after MemRead.
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_rdata <= '0;
    end else begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (MemWrite) mem[mem_addr] <= mem_wdata;
      if (MemRead) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Raise the enabled requests together and check every cycle against the
  // round-robin transaction model until the last completion is visible.
  task automatic run_txns(input bit c_en, input bit c_we, input logic [AW-1:0] c_a, input logic [DW-1:0] c_d,
                          input bit d_en, input bit d_we, input logic [AW-1:0] d_a, input logic [DW-1:0] d_d);
    int            n;
    int            start;
    int            last;
    bit            tid [2];
    bit            twe [2];
    logic [AW-1:0] ta [2];
    logic [DW-1:0] td [2];
    int            sstep [2];
    int            astep [2];
    bit            exp_owner, e_mr, e_mw, e_ca, e_da, e_busy;

    if (c_en && d_en) begin
      tid[0] = !m_owner;
      tid[1] = m_owner;
      n = 2;
    end else begin
      tid[0] = d_en;
      tid[1] = 1'b0;
      n = 1;
    end
    start = 1;
    for (int i = 0; i < n; i++) begin
      twe[i]   = tid[i] ? d_we : c_we;
      ta[i]    = tid[i] ? d_a : c_a;
      td[i]    = tid[i] ? d_d : c_d;
      sstep[i] = start;
      astep[i] = start + (twe[i] ? 0 : 1);
      start    = astep[i] + 2;
    end
    last = astep[n-1] + 1;

    cpu_req = c_en; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
    dev_req = d_en; dev_we = d_we; dev_addr = d_a; dev_wdata = d_d;
    exp_owner = m_owner;

    for (int s = 1; s <= last; s++) begin
      step();
      e_mr = 0; e_mw = 0; e_ca = 0; e_da = 0; e_busy = 0;
      for (int i = 0; i < n; i++) begin
        if (s == sstep[i]) begin
          exp_owner = tid[i];
          e_mr = !twe[i];
          e_mw = twe[i];
          check("mem_addr", 32'(mem_addr), 32'(ta[i]));
          if (twe[i]) check("mem_wdata", 32'(mem_wdata), 32'(td[i]));
        end
        if (s >= sstep[i] && s <= astep[i]) e_busy = 1;
        if (s == astep[i]) begin
          if (tid[i]) e_da = 1; else e_ca = 1;
          if (twe[i]) ref_mem[ta[i]] = td[i];
        end
        if (s == astep[i] + 1 && !twe[i]) m_rdata[tid[i]] = ref_mem[ta[i]];
      end
      check("MemRead", 32'(MemRead), 32'(e_mr));
      check("MemWrite", 32'(MemWrite), 32'(e_mw));
      check("strobe_excl", 32'(MemRead & MemWrite), 32'd0);
      check("cpu_ack", 32'(cpu_ack), 32'(e_ca));
      check("dev_ack", 32'(dev_ack), 32'(e_da));
      check("busy", 32'(busy), 32'(e_busy));
      check("owner", 32'(owner), 32'(exp_owner));
      check("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata[0]));
      check("dev_rdata", 32'(dev_rdata), 32'(m_rdata[1]));
      for (int i = 0; i < n; i++) begin
        if (s == sstep[i]) begin
          if (tid[i]) begin
            dev_addr = AW'($urandom); dev_wdata = DW'($urandom); dev_we = 1'($urandom);
          end else begin
            cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom); cpu_we = 1'($urandom);
          end
        end
        if (s == astep[i]) begin
          if (tid[i]) dev_req = 1'b0; else cpu_req = 1'b0;
        end
      end
    end
    m_owner = exp_owner;
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dev_req = 0; dev_we = 0; dev_addr = '0; dev_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_mem[8'h10] = 16'hBEEF;
    m_rdata[0] = '0; m_rdata[1] = '0; m_owner = 1'b1;
    repeat (2) step();
    preload = 1'b0; pl_we = 1'b1; pl_addr = 8'h10; pl_data = 16'hBEEF;
    step();
    pl_we = 1'b0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd1);
    check("rst_strobes", 32'({MemRead, MemWrite, cpu_ack, dev_ack}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_dev_rdata", 32'(dev_rdata), 32'd0);
    reset = 1'b0;

    run_txns(1, 0, 8'h10, 16'h0, 0, 0, 8'h0, 16'h0);
    check("beef_read", 32'(cpu_rdata), 32'h0000BEEF);
    run_txns(0, 0, 8'h0, 16'h0, 1, 1, 8'h22, 16'h1234);
    run_txns(1, 0, 8'h22, 16'h0, 0, 0, 8'h0, 16'h0);
    check("dev_wr_readback", 32'(cpu_rdata), 32'h00001234);

    reset = 1'b1; step(); reset = 1'b0;
    m_rdata[0] = '0; m_rdata[1] = '0; m_owner = 1'b1;
    run_txns(1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
    run_txns(1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
    run_txns(1, 0, 8'h05, 16'h0, 0, 0, 8'h0, 16'h0);

    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h33;
    step();
    check("midrd_memread", 32'(MemRead), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrd_memread_drop", 32'(MemRead), 32'd0);
    check("midrd_busy", 32'(busy), 32'd0);
    check("midrd_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("midrd_owner", 32'(owner), 32'd1);
    cpu_req = 0;
    step();
    reset = 1'b0;
    m_rdata[0] = '0; m_rdata[1] = '0; m_owner = 1'b1;
    repeat (3) begin
      step();
      check("midrd_no_ack", 32'({cpu_ack, dev_ack, MemRead, MemWrite}), 32'd0);
      check("midrd_rdata_kept", 32'(cpu_rdata), 32'd0);
    end
    run_txns(1, 0, 8'h33, 16'h0, 0, 0, 8'h0, 16'h0);

    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 16'h1111;
    step();
    check("b2b_w1", 32'({MemWrite, MemRead, cpu_ack}), 32'b101);
    check("b2b_w1_data", 32'(mem_wdata), 32'h1111);
    cpu_addr = 8'h41; cpu_wdata = 16'h2222;
    step();
    check("b2b_gap", 32'({MemWrite, MemRead, cpu_ack, busy}), 32'd0);
    step();
    check("b2b_w2", 32'({MemWrite, MemRead, cpu_ack}), 32'b101);
    check("b2b_w2_addr", 32'(mem_addr), 32'h41);
    check("b2b_w2_data", 32'(mem_wdata), 32'h2222);
    cpu_req = 0;
    ref_mem[8'h40] = 16'h1111; ref_mem[8'h41] = 16'h2222; m_owner = 1'b0;
    step();
    check("b2b_idle", 32'({MemWrite, cpu_ack, busy}), 32'd0);
    run_txns(1, 0, 8'h40, 16'h0, 1, 0, 8'h41, 16'h0);

    for (int k = 0; k < 40; k++) begin
      bit ce, de;
      ce = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1));
      if (!ce && !de) ce = 1'b1;
      run_txns(ce, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
               de, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
